// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// One shift-add or restoring-divide step per cycle; stalls EX while busy.
module muldiv_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int FUNCT_WIDTH = 6,
   parameter int CNT_WIDTH   = $clog2(DATA_WIDTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [FUNCT_WIDTH-1:0] funct,
   input  logic [DATA_WIDTH-1:0]  operand_a,
   input  logic [DATA_WIDTH-1:0]  operand_b,
   input  logic                   flush,
   output logic                   stall_req,
   output logic                   done,
   output logic [DATA_WIDTH-1:0]  hi,
   output logic [DATA_WIDTH-1:0]  lo,
   output logic [DATA_WIDTH-1:0]  rdata
);

   localparam int W = DATA_WIDTH;

   localparam logic [FUNCT_WIDTH-1:0] F_MFHI  = FUNCT_WIDTH'(16);
   localparam logic [FUNCT_WIDTH-1:0] F_MTHI  = FUNCT_WIDTH'(17);
   localparam logic [FUNCT_WIDTH-1:0] F_MFLO  = FUNCT_WIDTH'(18);
   localparam logic [FUNCT_WIDTH-1:0] F_MTLO  = FUNCT_WIDTH'(19);
   localparam logic [FUNCT_WIDTH-1:0] F_MULT  = FUNCT_WIDTH'(24);
   localparam logic [FUNCT_WIDTH-1:0] F_MULTU = FUNCT_WIDTH'(25);
   localparam logic [FUNCT_WIDTH-1:0] F_DIV   = FUNCT_WIDTH'(26);
   localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = FUNCT_WIDTH'(27);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV
   } state_t;

   state_t state, state_nxt;

   logic is_mul, is_div, is_sgn;
   logic is_mthi, is_mtlo, is_mfhi, is_mflo;
   logic accept, last;

   logic [CNT_WIDTH-1:0] cnt;
   logic [W-1:0]         opnd;
   logic [2*W-1:0]       acc;
   logic                 neg_q, neg_r;

   logic         a_neg, b_neg;
   logic [W-1:0] a_mag, b_mag;

   logic [W:0]     mul_sum;
   logic [W:0]     div_sh, div_diff;
   logic [W-1:0]   div_rem;
   logic [2*W-1:0] step, prod;
   logic [W-1:0]   res_hi, res_lo;

   always_comb begin
      is_mul  = 1'b0;
      is_div  = 1'b0;
      is_sgn  = 1'b0;
      is_mthi = 1'b0;
      is_mtlo = 1'b0;
      is_mfhi = 1'b0;
      is_mflo = 1'b0;
      case (funct)
         F_MFHI:  is_mfhi = 1'b1;
         F_MTHI:  is_mthi = 1'b1;
         F_MFLO:  is_mflo = 1'b1;
         F_MTLO:  is_mtlo = 1'b1;
         F_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
         F_MULTU: is_mul = 1'b1;
         F_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
         F_DIVU:  is_div = 1'b1;
         default: ;
      endcase
   end

   assign accept    = en & (state == S_IDLE) & ~flush;
   assign stall_req = (state != S_IDLE) | (accept & (is_mul | is_div));
   assign last      = (cnt == CNT_WIDTH'(W - 1));

   always_comb begin
      rdata = '0;
      if (is_mfhi) rdata = hi;
      else if (is_mflo) rdata = lo;
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept & is_mul) state_nxt = S_MUL;
            else if (accept & is_div) state_nxt = S_DIV;
         end
         S_MUL, S_DIV: begin
            if (flush | last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign a_neg = is_sgn & operand_a[W-1];
   assign b_neg = is_sgn & operand_b[W-1];
   assign a_mag = a_neg ? -operand_a : operand_a;
   assign b_mag = b_neg ? -operand_b : operand_b;

   // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   always_comb begin
      mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
      div_sh   = {acc[2*W-1:W], acc[W-1]};
      div_diff = div_sh - {1'b0, opnd};
      div_rem  = div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0];
      if (state == S_MUL) step = {mul_sum, acc[W-1:1]};
      else step = {div_rem, acc[W-2:0], ~div_diff[W]};
      prod   = neg_q ? -step : step;
      res_hi = prod[2*W-1:W];
      res_lo = prod[W-1:0];
      if (state == S_DIV) begin
         res_lo = neg_q ? -step[W-1:0] : step[W-1:0];
         res_hi = neg_r ? -step[2*W-1:W] : step[2*W-1:W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         acc   <= '0;
         opnd  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            cnt <= '0;
            if (accept & is_mthi) hi <= operand_a;
            if (accept & is_mtlo) lo <= operand_a;
            if (accept & (is_mul | is_div)) begin
               opnd  <= is_mul ? a_mag : b_mag;
               acc   <= {{W{1'b0}}, is_mul ? b_mag : a_mag};
               // a zero divisor keeps the all-ones quotient unsigned
               neg_q <= (a_neg ^ b_neg) & (is_mul | (operand_b != '0));
               neg_r <= is_div & a_neg;
            end
         end else if (flush) begin
            cnt <= '0;
         end else begin
            acc <= step;
            cnt <= cnt + 1'b1;
            if (last) begin
               hi   <= res_hi;
               lo   <= res_lo;
               done <= 1'b1;
               cnt  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at 32-bit and 8-bit widths.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [5:0]  funct = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        flush = 1'b0;
   logic        stall_req, done;
   logic [31:0] hi, lo, rdata;

   logic       en8 = 1'b0;
   logic [5:0] funct8 = '0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       stall8, done8;
   logic [7:0] hi8, lo8, rdata8;

   int total = 0;
   int bad = 0;
   int n;
   int seen;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .en(en), .funct(funct),
      .operand_a(a), .operand_b(b), .flush(flush),
      .stall_req(stall_req), .done(done),
      .hi(hi), .lo(lo), .rdata(rdata)
   );

   muldiv_unit #(.DATA_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .en(en8), .funct(funct8),
      .operand_a(a8), .operand_b(b8), .flush(1'b0),
      .stall_req(stall8), .done(done8),
      .hi(hi8), .lo(lo8), .rdata(rdata8)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mt(input logic [5:0] f, input logic [31:0] v);
      en = 1'b1; funct = f; a = v;
      tick();
      en = 1'b0; funct = '0;
      #1;
   endtask

   task automatic op32(input string tag, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el);
      en = 1'b1; funct = f; a = x; b = y;
      #1;
      n = 0;
      while (stall_req && n < 100) begin
         n++;
         tick();
         en = 1'b0;
         #1;
      end
      chk({tag, "_stall"}, 64'(n), 64'd33);
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_hi"}, 64'(hi), 64'(eh));
      chk({tag, "_lo"}, 64'(lo), 64'(el));
      en = 1'b1; funct = 6'h10;
      #1;
      chk({tag, "_mfhi"}, 64'(rdata), 64'(eh));
      tick();
      en = 1'b0; funct = '0;
      #1;
      chk({tag, "_done_low"}, 64'(done), 64'd0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_stall", 64'(stall_req), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      rst = 1'b1;
      tick();

      mt(6'h11, 32'h1234_5678);
      mt(6'h13, 32'hDEAD_BEEF);
      chk("mthi", 64'(hi), 64'h1234_5678);
      chk("mtlo", 64'(lo), 64'hDEAD_BEEF);
      en = 1'b1; funct = 6'h10;
      #1;
      chk("mfhi", 64'(rdata), 64'h1234_5678);
      tick();
      funct = 6'h12;
      #1;
      chk("mflo", 64'(rdata), 64'hDEAD_BEEF);
      tick();
      en = 1'b0; funct = '0;

      op32("mult", 6'h18, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      op32("multu", 6'h19, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE);
      op32("div", 6'h1A, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      op32("divu", 6'h1B, 32'h7, 32'h2, 32'h1, 32'h3);
      op32("divu0", 6'h1B, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF);
      op32("divmin", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      op32("div0s", 6'h1A, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // flush mid-multiply
      mt(6'h11, 32'hAA);
      mt(6'h13, 32'h55);
      en = 1'b1; funct = 6'h18; a = 32'h3; b = 32'h5;
      tick();
      en = 1'b0; funct = '0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_stall", 64'(stall_req), 64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) seen++;
         tick();
      end
      chk("flush_done", 64'(seen), 64'd0);
      chk("flush_hi", 64'(hi), 64'hAA);
      chk("flush_lo", 64'(lo), 64'h55);

      // reset mid-multiply
      en = 1'b1; funct = 6'h18; a = 32'h3; b = 32'h5;
      tick();
      en = 1'b0; funct = '0;
      repeat (9) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("rstmid_stall", 64'(stall_req), 64'd0);
      chk("rstmid_hi", 64'(hi), 64'd0);
      chk("rstmid_lo", 64'(lo), 64'd0);
      chk("rstmid_done", 64'(done), 64'd0);

      // 8-bit instance
      en8 = 1'b1; funct8 = 6'h19; a8 = 8'hFF; b8 = 8'hFF;
      #1;
      n = 0;
      while (stall8 && n < 100) begin
         n++;
         tick();
         en8 = 1'b0;
         #1;
      end
      chk("w8_stall", 64'(n), 64'd9);
      chk("w8_done", 64'(done8), 64'd1);
      chk("w8_hi", 64'(hi8), 64'hFE);
      chk("w8_lo", 64'(lo8), 64'h01);
      en8 = 1'b1; funct8 = 6'h18; a8 = 8'hFD; b8 = 8'h02;
      #1;
      chk("w8_accept_stall", 64'(stall8), 64'd1);
      tick();
      en8 = 1'b0; funct8 = '0;
      #1;
      chk("w8_busy", 64'(stall8), 64'd1);
      n = 0;
      while (!done8 && n < 30) begin
         n++;
         tick();
      end
      chk("w8_b2b_lat", 64'(n), 64'd8);
      chk("w8_b2b_hi", 64'(hi8), 64'hFF);
      chk("w8_b2b_lo", 64'(lo8), 64'hFA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the EX stage of the MIPS pipeline. It consumes the SPECIAL-class `funct` that the ID stage forwards for R-type instructions and executes MULT/MULTU/DIV/DIVU over several cycles while raising a stall request. It also services MFHI/MFLO/MTHI/MTLO. It is the parametrised, sequential successor to the combinational funct decode: width, iteration count and the signed-arithmetic path are generic, and it carries HI/LO state across instructions.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand, HI and LO width (W); must be ≥ 4.
- `FUNCT_WIDTH`, 6, width of `funct`.
- `CNT_WIDTH`, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `en`  in  1  EX-stage instruction valid; `funct` and operands are meaningful only when `en`=1.
- `funct`  in  FUNCT_WIDTH  SPECIAL funct field.
- `operand_a`  in  W  rs value; dividend/multiplicand/MT source.
- `operand_b`  in  W  rt value; divisor/multiplier.
- `flush`  in  1  pipeline flush; aborts any operation in progress.
- `stall_req`  out  1  hold ID/EX while high.
- `done`  out  1  one-cycle pulse when HI/LO receive a mul/div result.
- `hi`, `lo`  out  W  current HI/LO register contents.
- `rdata`  out  W  MFHI returns `hi`, MFLO returns `lo`, every other funct returns 0 (combinational).

## Operation
- Decode uses the `FUNCT_*` codes from `funct.v`: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. All other codes have no effect on state.
- States:
  - IDLE → MUL on MULT/MULTU.
  - IDLE → DIV on DIV/DIVU.
  - MUL/DIV → IDLE after W iterations, or on `flush`.
- Accept condition: `en`=1, state IDLE, `flush`=0. An accepted operation latches the operands into internal registers. For signed ops it latches magnitudes plus the result sign bits.
- MUL: radix-2 shift-add, one multiplier bit per cycle, giving a 2W-bit product.
  - HI receives product[2W-1:W]; LO receives product[W-1:0].
  - Signed: the product is negated when the operand signs differ.
- DIV: restoring division, one quotient bit per cycle on magnitudes.
  - LO receives the quotient, truncated toward zero. HI receives the remainder, which takes the sign of the dividend.
  - Divide by zero (unsigned or signed): LO = all ones, HI = dividend magnitude with dividend sign applied. This case is not trapped.
  - Signed MIN / −1: LO = MIN, HI = 0.
- MTHI/MTLO: when `en`=1, state IDLE and `flush`=0, write `operand_a` to HI or LO at the edge.
- Any `en` instruction presented while not IDLE has no effect. The pipeline is stalled, so the same instruction is re-presented later.
- `flush` in any state:
  - returns to IDLE at the next edge;
  - discards the partial result, leaving HI/LO unchanged;
  - produces no `done`;
  - blocks acceptance in that cycle.
- Reset (`rst`=0 at an edge): state IDLE, counter 0, HI = 0, LO = 0, `done` = 0. Reset wins over every other input, including mid-operation.

## Timing
- Accept at edge E0. State is MUL/DIV for exactly W cycles after E0.
- `stall_req` is combinational:
  - It is 1 whenever state ≠ IDLE.
  - It is also 1 in the accept cycle when `en` carries a mul/div funct (so the instruction holds from its first EX cycle).
  - Total stall is W+1 cycles.
- HI/LO are written at edge E0+W, the final iteration, with sign fixup applied combinationally at that write. `done` = 1 during cycle E0+W+1 only. `stall_req` = 0 in that cycle.
- An MFHI/MFLO arriving back-to-back is stalled by `stall_req`. It therefore reads the new HI/LO combinationally via `rdata` in the `done` cycle.
- `en` with a new MULT in the `done` cycle is accepted (state is IDLE).
- MTHI/MTLO take effect at the edge of their EX cycle. `rdata` for a following MFHI/MFLO sees the new value one cycle later.
- Outputs after reset: `stall_req` = 0 (with `en` = 0), `done` = 0, `hi` = 0, `lo` = 0, `rdata` = 0.

## Test plan
- Reset, then MTHI 0x1234_5678 and MTLO 0xDEAD_BEEF.
  - Required: `hi`/`lo` hold those values one cycle later.
  - Required: MFHI then MFLO give `rdata` 0x1234_5678, then 0xDEAD_BEEF.
- MULT 0xFFFF_FFFF × 0x0000_0002 (i.e. −1 × 2).
  - Required: `stall_req` high for 33 cycles, `done` pulses once.
  - Required: HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFE.
  - Repeat as MULTU. Required: HI = 0x0000_0001, LO = 0xFFFF_FFFE.
- DIV −7 / 2. Required: LO = 0xFFFF_FFFD (−3), HI = 0xFFFF_FFFF (−1).
  - DIVU 7 / 2. Required: LO = 3, HI = 1.
- DIVU 5 / 0. Required: LO = 0xFFFF_FFFF, HI = 5.
  - DIV 0x8000_0000 / 0xFFFF_FFFF. Required: LO = 0x8000_0000, HI = 0.
- Start MULT with HI/LO preloaded to 0xAA/0x55, then assert `flush` on iteration 10.
  - Required: IDLE next cycle, no `done`, HI/LO stay 0xAA/0x55.
  - Repeat, but drive `rst`=0 at iteration 10. Required: HI = LO = 0, `stall_req` = 0.
- `DATA_WIDTH`=8, MULTU 0xFF × 0xFF.
  - Required: stall 9 cycles, HI = 0xFE, LO = 0x01.
  - Also issue a MULT in the `done` cycle. Required: it is accepted immediately.
